// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if -- bundle of every non-clock/reset signal of draw_scheduler.
//   Frame/dirty pulses in:   frame_tick, map_dirty_set, HUD_dirty_set
//   Drawer handshake:        draw_map/draw_HUD/draw_sprite (level enables out),
//                            draw_map_done/draw_HUD_done/draw_sprite_done (pulses in)
//   Drawer pixel buses in:   map_*/HUD_*/spr_* x(9) y(8) colour(3) write(1)
//   Shared VGA port out:     VGA_x, VGA_y, VGA_colour, VGA_write
//   Status out:              busy, frame_overrun, timeout_err, state_dbg
// modport slave is the scheduler side; modport master is the driving side.
interface draw_scheduler_if;
  logic       frame_tick;
  logic       map_dirty_set;
  logic       HUD_dirty_set;
  logic       draw_map;
  logic       draw_HUD;
  logic       draw_sprite;
  logic       draw_map_done;
  logic       draw_HUD_done;
  logic       draw_sprite_done;
  logic [8:0] map_x;
  logic [7:0] map_y;
  logic [2:0] map_colour;
  logic       map_write;
  logic [8:0] HUD_x;
  logic [7:0] HUD_y;
  logic [2:0] HUD_colour;
  logic       HUD_write;
  logic [8:0] spr_x;
  logic [7:0] spr_y;
  logic [2:0] spr_colour;
  logic       spr_write;
  logic [8:0] VGA_x;
  logic [7:0] VGA_y;
  logic [2:0] VGA_colour;
  logic       VGA_write;
  logic       busy;
  logic       frame_overrun;
  logic       timeout_err;
  logic [1:0] state_dbg;

  modport slave (
    input  frame_tick, map_dirty_set, HUD_dirty_set,
    input  draw_map_done, draw_HUD_done, draw_sprite_done,
    input  map_x, map_y, map_colour, map_write,
    input  HUD_x, HUD_y, HUD_colour, HUD_write,
    input  spr_x, spr_y, spr_colour, spr_write,
    output draw_map, draw_HUD, draw_sprite,
    output VGA_x, VGA_y, VGA_colour, VGA_write,
    output busy, frame_overrun, timeout_err, state_dbg
  );

  modport master (
    output frame_tick, map_dirty_set, HUD_dirty_set,
    output draw_map_done, draw_HUD_done, draw_sprite_done,
    output map_x, map_y, map_colour, map_write,
    output HUD_x, HUD_y, HUD_colour, HUD_write,
    output spr_x, spr_y, spr_colour, spr_write,
    input  draw_map, draw_HUD, draw_sprite,
    input  VGA_x, VGA_y, VGA_colour, VGA_write,
    input  busy, frame_overrun, timeout_err, state_dbg
  );
endinterface

// File: rtl/draw_scheduler.sv
// draw_scheduler -- per-frame sequencer for the map, HUD and sprite drawers.
// On frame_tick it runs MAP (if map dirty), HUD (if HUD dirty), then SPRITE
// (every frame), and muxes the active drawer's pixel bus onto the VGA port.
// Ports:
//   clock   : system clock, all logic on posedge
//   reset   : synchronous active-high reset (sets both dirty flags)
//   bus     : draw_scheduler_if.slave, see interface header
// Drawer handshake: draw_<x> is a level enable held high for the whole phase;
// the drawer answers with a one-cycle draw_<x>_done. A done is only honoured
// while its own enable is high, and the phase ends on the following edge.
module draw_scheduler #(
  parameter logic [16:0] TIMEOUT = 17'd100000
) (
  input logic             clock,
  input logic             reset,
  draw_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MAP = 2'd1, HUD = 2'd2, SPRITE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [16:0] phase_cnt;
  logic        map_dirty, hud_dirty;
  logic        map_clr, hud_clr, timeout_hit, phase_expired;
  logic        frame_overrun_q, timeout_err_q;

  assign phase_expired = (phase_cnt == TIMEOUT - 17'd1);

  always_comb begin
    state_d     = state_q;
    map_clr     = 1'b0;
    hud_clr     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          if (map_dirty)      state_d = MAP;
          else if (hud_dirty) state_d = HUD;
          else                state_d = SPRITE;
        end
      end
      MAP: begin
        if (bus.draw_map_done) begin
          map_clr = 1'b1;
          state_d = hud_dirty ? HUD : SPRITE;
        end else if (phase_expired) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      HUD: begin
        if (bus.draw_HUD_done) begin
          hud_clr = 1'b1;
          state_d = SPRITE;
        end else if (phase_expired) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      SPRITE: begin
        if (bus.draw_sprite_done) begin
          state_d = IDLE;
        end else if (phase_expired) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      phase_cnt       <= 17'd0;
      map_dirty       <= 1'b1;
      hud_dirty       <= 1'b1;
      frame_overrun_q <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counter restarts on any state change and idles at zero.
      if (state_d != state_q || state_q == IDLE) phase_cnt <= 17'd0;
      else                                       phase_cnt <= phase_cnt + 17'd1;
      // A set pulse beats a same-cycle clear so the new request is not lost.
      map_dirty       <= bus.map_dirty_set | (map_dirty & ~map_clr);
      hud_dirty       <= bus.HUD_dirty_set | (hud_dirty & ~hud_clr);
      // Ticks outside IDLE are dropped, including one that coincides with
      // the sprite done.
      frame_overrun_q <= bus.frame_tick && (state_q != IDLE);
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign bus.draw_map      = (state_q == MAP);
  assign bus.draw_HUD      = (state_q == HUD);
  assign bus.draw_sprite   = (state_q == SPRITE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.frame_overrun = frame_overrun_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.state_dbg     = state_q;

  always_comb begin
    bus.VGA_x      = 9'd0;
    bus.VGA_y      = 8'd0;
    bus.VGA_colour = 3'd0;
    bus.VGA_write  = 1'b0;
    case (state_q)
      MAP: begin
        bus.VGA_x      = bus.map_x;
        bus.VGA_y      = bus.map_y;
        bus.VGA_colour = bus.map_colour;
        bus.VGA_write  = bus.map_write;
      end
      HUD: begin
        bus.VGA_x      = bus.HUD_x;
        bus.VGA_y      = bus.HUD_y;
        bus.VGA_colour = bus.HUD_colour;
        bus.VGA_write  = bus.HUD_write;
      end
      SPRITE: begin
        bus.VGA_x      = bus.spr_x;
        bus.VGA_y      = bus.spr_y;
        bus.VGA_colour = bus.spr_colour;
        bus.VGA_write  = bus.spr_write;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler -- directed vector table plus hand-written sequences for
// timeout, VGA muxing and mid-phase reset of draw_scheduler (TIMEOUT=16).
module tb_draw_scheduler;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  draw_scheduler_if dsi ();

  draw_scheduler #(.TIMEOUT(17'd16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dsi)
  );

  always #5 clock = ~clock;

  // {tick, map_set, hud_set, map_done, hud_done, spr_done} |
  // {exp draw_map, draw_HUD, draw_sprite, busy, frame_overrun}
  typedef struct packed {
    logic tick, mset, hset, mdone, hdone, sdone;
    logic e_map, e_hud, e_spr, e_busy, e_ovr;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic tick, input logic mset, input logic hset,
                       input logic md, input logic hd, input logic sd);
    dsi.frame_tick       = tick;
    dsi.map_dirty_set    = mset;
    dsi.HUD_dirty_set    = hset;
    dsi.draw_map_done    = md;
    dsi.draw_HUD_done    = hd;
    dsi.draw_sprite_done = sd;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_enables(input string tag, input logic m, input logic h,
                               input logic s, input logic b);
    check({tag, " draw_map"},    {31'd0, dsi.draw_map},    {31'd0, m});
    check({tag, " draw_HUD"},    {31'd0, dsi.draw_HUD},    {31'd0, h});
    check({tag, " draw_sprite"}, {31'd0, dsi.draw_sprite}, {31'd0, s});
    check({tag, " busy"},        {31'd0, dsi.busy},        {31'd0, b});
  endtask

  initial begin
    vecs[0]  = 11'b000000_00000; // idle
    vecs[1]  = 11'b100000_10010; // tick -> MAP
    vecs[2]  = 11'b000000_10010;
    vecs[3]  = 11'b000001_10010; // stray sprite done ignored
    vecs[4]  = 11'b000100_01010; // map done -> HUD
    vecs[5]  = 11'b000010_00110; // HUD done -> SPRITE
    vecs[6]  = 11'b000001_00000; // sprite done -> IDLE
    vecs[7]  = 11'b100000_00110; // nothing dirty -> SPRITE only
    vecs[8]  = 11'b000000_00110;
    vecs[9]  = 11'b000001_00000;
    vecs[10] = 11'b001000_00000; // HUD dirty
    vecs[11] = 11'b100000_01010; // -> HUD
    vecs[12] = 11'b001010_00110; // HUD done + HUD set: set wins
    vecs[13] = 11'b000001_00000;
    vecs[14] = 11'b100000_01010; // HUD still dirty, MAP skipped
    vecs[15] = 11'b000010_00110;
    vecs[16] = 11'b100001_00001; // tick + sprite done = overrun
    vecs[17] = 11'b000000_00000; // tick not queued
    vecs[18] = 11'b010000_00000; // map dirty
    vecs[19] = 11'b100000_10010; // -> MAP
    vecs[20] = 11'b100000_10011; // tick in MAP: overrun
    vecs[21] = 11'b000000_10010; // single-cycle pulse
    vecs[22] = 11'b000100_00110; // map done, HUD clean -> SPRITE
    vecs[23] = 11'b000001_00000;
    vecs[24] = 11'b000000_00000; // no extra frame

    drive(0, 0, 0, 0, 0, 0);
    dsi.map_x = 9'd0;   dsi.map_y = 8'd0;  dsi.map_colour = 3'd0; dsi.map_write = 1'b0;
    dsi.HUD_x = 9'd0;   dsi.HUD_y = 8'd0;  dsi.HUD_colour = 3'd0; dsi.HUD_write = 1'b0;
    dsi.spr_x = 9'd0;   dsi.spr_y = 8'd0;  dsi.spr_colour = 3'd0; dsi.spr_write = 1'b0;

    // Reset state.
    reset = 1'b1;
    step(); step();
    check_enables("reset", 0, 0, 0, 0);
    check("reset frame_overrun", {31'd0, dsi.frame_overrun}, 32'd0);
    check("reset timeout_err",   {31'd0, dsi.timeout_err},   32'd0);
    check("reset VGA_write",     {31'd0, dsi.VGA_write},     32'd0);
    check("reset state_dbg",     {30'd0, dsi.state_dbg},     32'd0);
    reset = 1'b0;
    step();

    // Vector table.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].tick, vecs[i].mset, vecs[i].hset,
            vecs[i].mdone, vecs[i].hdone, vecs[i].sdone);
      step();
      check_enables($sformatf("v%0d", i), vecs[i].e_map, vecs[i].e_hud,
                    vecs[i].e_spr, vecs[i].e_busy);
      check($sformatf("v%0d frame_overrun", i), {31'd0, dsi.frame_overrun},
            {31'd0, vecs[i].e_ovr});
    end
    drive(0, 0, 0, 0, 0, 0);
    check("table timeout_err", {31'd0, dsi.timeout_err}, 32'd0);

    // Timeout: 16 cycles in MAP without done, then abort.
    drive(0, 1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    check_enables("to cycle1", 1, 0, 0, 1);
    for (int i = 2; i <= 16; i++) begin
      step();
      check($sformatf("to cycle%0d draw_map", i), {31'd0, dsi.draw_map}, 32'd1);
    end
    check("to before timeout_err", {31'd0, dsi.timeout_err}, 32'd0);
    step();
    check_enables("to abort", 0, 0, 0, 0);
    check("to timeout_err", {31'd0, dsi.timeout_err}, 32'd1);
    drive(1, 0, 0, 0, 0, 0); step();
    check_enables("to retick", 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0); step();
    check_enables("to map done", 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1); step();
    check_enables("to sprite done", 0, 0, 0, 0);
    check("to sticky timeout_err", {31'd0, dsi.timeout_err}, 32'd1);

    // VGA mux.
    dsi.map_x = 9'd5;   dsi.map_y = 8'd11; dsi.map_colour = 3'd1; dsi.map_write = 1'b1;
    dsi.HUD_x = 9'd200; dsi.HUD_y = 8'd7;  dsi.HUD_colour = 3'd3; dsi.HUD_write = 1'b1;
    dsi.spr_x = 9'd77;  dsi.spr_y = 8'd99; dsi.spr_colour = 3'd6; dsi.spr_write = 1'b1;
    drive(0, 0, 1, 0, 0, 0); step();
    check("vga idle VGA_write", {31'd0, dsi.VGA_write}, 32'd0);
    check("vga idle VGA_x",     {23'd0, dsi.VGA_x},     32'd0);
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    check_enables("vga hud", 0, 1, 0, 1);
    check("vga hud VGA_write",  {31'd0, dsi.VGA_write},  32'd1);
    check("vga hud VGA_x",      {23'd0, dsi.VGA_x},      32'd200);
    check("vga hud VGA_y",      {24'd0, dsi.VGA_y},      32'd7);
    check("vga hud VGA_colour", {29'd0, dsi.VGA_colour}, 32'd3);
    dsi.HUD_write = 1'b0; #1;
    check("vga hud write off", {31'd0, dsi.VGA_write}, 32'd0);
    drive(0, 0, 0, 0, 1, 0); step();
    check("vga spr VGA_x",      {23'd0, dsi.VGA_x},      32'd77);
    check("vga spr VGA_y",      {24'd0, dsi.VGA_y},      32'd99);
    check("vga spr VGA_colour", {29'd0, dsi.VGA_colour}, 32'd6);
    check("vga spr VGA_write",  {31'd0, dsi.VGA_write},  32'd1);
    drive(0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0);
    check("vga end VGA_write",  {31'd0, dsi.VGA_write},  32'd0);
    check("vga end VGA_x",      {23'd0, dsi.VGA_x},      32'd0);

    // Reset mid-phase with a coincident done.
    drive(1, 0, 0, 0, 0, 0); step();
    check_enables("rst pre", 0, 0, 1, 1);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1); step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check_enables("rst mid", 0, 0, 0, 0);
    check("rst mid timeout_err", {31'd0, dsi.timeout_err}, 32'd0);
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    check_enables("rst redraw", 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0); step();
    check_enables("rst redraw hud", 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 17'd100000, max cycles allowed per draw phase.
REQ-002 SHALL have port clock  input  1  single system clock, all logic on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port frame_tick  input  1  one-cycle pulse marking start of a frame.
REQ-005 SHALL have ports map_dirty_set, HUD_dirty_set  input  1 each  one-cycle pulses requesting map/HUD redraw.
REQ-006 SHALL have ports draw_map, draw_HUD, draw_sprite  output  1 each  level enables to the map, HUD and sprite drawers.
REQ-007 SHALL have ports draw_map_done, draw_HUD_done, draw_sprite_done  input  1 each  drawer completion pulses.
REQ-008 SHALL have per-requester ports map_/HUD_/spr_ x (9), y (8), colour (3), write (1)  input  drawer pixel outputs.
REQ-009 SHALL have ports VGA_x 9, VGA_y 8, VGA_colour 3, VGA_write 1  output  shared VGA memory write port.
REQ-010 SHALL have ports busy  output  1  high in any non-IDLE state; frame_overrun  output  1  one-cycle pulse; timeout_err  output  1  sticky.

Function
REQ-011 SHALL implement registered FSM with states IDLE, MAP, HUD, SPRITE.
REQ-012 SHALL hold flags map_dirty and HUD_dirty, each set by its *_dirty_set pulse.
REQ-013 SHALL, in IDLE on frame_tick at cycle t, enter MAP at t+1 if map_dirty, else HUD if HUD_dirty, else SPRITE.
REQ-014 SHALL, in MAP on draw_map_done, clear map_dirty and enter HUD if HUD_dirty, else SPRITE, on next cycle.
REQ-015 SHALL, in HUD on draw_HUD_done, clear HUD_dirty and enter SPRITE on next cycle.
REQ-016 SHALL, in SPRITE on draw_sprite_done, enter IDLE on next cycle; sprite phase runs every frame.
REQ-017 SHALL drive draw_map/draw_HUD/draw_sprite high exactly while in MAP/HUD/SPRITE; at most one enable high in any cycle.
REQ-018 SHALL ignore done inputs not matching the current state.
REQ-019 SHALL give a *_dirty_set pulse priority over a same-cycle clear; flag stays 1 and is redrawn next frame.
REQ-020 SHALL, on frame_tick when not IDLE, ignore the tick, stay in current state, and pulse frame_overrun for one cycle.
REQ-021 SHALL treat frame_tick and the SPRITE done in the same cycle as overrun; the tick is not queued.
REQ-022 SHALL mux VGA_x/y/colour/write from the requester matching current state, combinationally from the state register.
REQ-023 SHALL drive VGA_write 0 and VGA_x/y/colour 0 in IDLE; writes from non-selected requesters never reach VGA.
REQ-024 SHALL keep a 17-bit phase counter, cleared on every state entry, incremented each cycle in MAP/HUD/SPRITE.
REQ-025 SHALL, when phase counter reaches TIMEOUT-1 without done, abort to IDLE, set timeout_err, and leave that phase's dirty flag set.
REQ-026 SHALL keep timeout_err high until reset.

Reset
REQ-027 SHALL, on reset, force state IDLE, phase counter 0, all enables 0, VGA outputs 0, busy 0, frame_overrun 0, timeout_err 0.
REQ-028 SHALL, on reset, set map_dirty=1 and HUD_dirty=1 so first frame redraws everything.
REQ-029 SHALL, on reset asserted mid-phase, deassert the active enable on the next cycle and discard any done arriving with reset.

Verification
REQ-030 Reset, then frame_tick -> draw_map high next cycle; map done -> draw_HUD; HUD done -> draw_sprite; sprite done -> IDLE, busy 0.
REQ-031 No dirty sets after a full frame, frame_tick -> draw_sprite high at t+1, draw_map and draw_HUD stay 0.
REQ-032 HUD_dirty_set in the same cycle as draw_HUD_done -> HUD_dirty remains 1; next frame_tick enters HUD, skipping MAP.
REQ-033 frame_tick while in MAP -> frame_overrun high for exactly 1 cycle, state stays MAP, no extra frame started afterwards.
REQ-034 TIMEOUT=16, hold done low in MAP -> IDLE after 16 cycles in MAP, timeout_err=1, next tick re-enters MAP.
REQ-035 In HUD, map_write=1 with map_x=9'd5 and HUD_write=1 with HUD_x=9'd200 -> VGA_write=1 with VGA_x=9'd200 only.
